id_ex_operand_stage: RTL and testbench
======================================

Name: id_ex_operand_stage

Overview:
- ID/EX pipeline stage downstream of the 16x32 register file. It consumes register-file read ports PA and PB, plus the read selects A and B that drive them.
- Resolves operands by forwarding from EX, MEM and WB, and substitutes PC+8 for R15 reads.
- Detects load-use hazards, requests a stall, and registers operands and control into the EX stage with bubble and hold support.

Parameters:
- DW, 32, operand/data width
- RW, 4, register-number width (16 registers)
- PC_OFFSET, 8, value added to the ID-stage PC when R15 is read

Ports:
- Clk  in  1  rising-edge clock
- Reset  in  1  synchronous, active-high; clears the stage on the Clk edge where it is 1
- PA  in  DW  register file port A data (selected by A)
- PB  in  DW  register file port B data (selected by B)
- A  in  RW  source register number for operand A (also drives the register file)
- B  in  RW  source register number for operand B
- UseA  in  1  instruction reads A
- UseB  in  1  instruction reads B
- PC_ID  in  DW  address of the instruction in ID
- Dst_ID  in  RW  destination register of the ID instruction
- WrEn_ID  in  1  ID instruction writes Dst_ID
- Valid_ID  in  1  ID holds a real instruction
- Flush  in  1  branch taken; kill the ID instruction
- Hold  in  1  downstream multi-cycle busy; freeze this stage
- Ex_Res, Mem_Res, Wb_Res  in  DW each  result of the EX, MEM and WB stages
- Ex_Dst, Mem_Dst, Wb_Dst  in  RW each  destination register of each stage
- Ex_WrEn, Mem_WrEn, Wb_WrEn  in  1 each  write enable of each stage
- Ex_IsLoad  in  1  EX instruction is a load (result not ready until MEM)
- OpA_EX  out  DW  registered operand A
- OpB_EX  out  DW  registered operand B
- Dst_EX  out  RW  registered destination
- WrEn_EX  out  1  registered write enable
- Valid_EX  out  1  registered valid
- Stall  out  1  combinational; freeze PC and IF/ID this cycle
- FwdA  out  2  combinational; forwarding source select for A, for debug/coverage
- FwdB  out  2  combinational; forwarding source select for B, for debug/coverage

Behaviour:
- Reset sampled at the Clk edge: OpA_EX=0, OpB_EX=0, Dst_EX=0, WrEn_EX=0, Valid_EX=0. Reset overrides Hold and Flush.
- Operand selection is combinational, evaluated independently for A and B (example for A):
  - If A==15: operand = PC_ID+PC_OFFSET, with mod 2^DW wrap. FwdA=0. No forwarding.
  - Else if Ex_WrEn and Ex_Dst==A and Ex_Dst!=15 and not Ex_IsLoad: Ex_Res, FwdA=1.
  - Else if Mem_WrEn and Mem_Dst==A and Mem_Dst!=15: Mem_Res, FwdA=2.
  - Else if Wb_WrEn and Wb_Dst==A and Wb_Dst!=15: Wb_Res, FwdA=3.
  - Else: PA, FwdA=0.
- Priority is youngest first: EX > MEM > WB > register file. Multiple matches resolve to the youngest stage.
- Load-use detection: Stall = Valid_ID & Ex_IsLoad & Ex_WrEn & Ex_Dst!=15 & ((UseA & A==Ex_Dst) | (UseB & B==Ex_Dst)) & ~Flush & ~Hold.
  - Sources with UseX=0 never cause a stall.
  - A source of 15 never stalls, because Ex_Dst!=15 is required.
- Register update on the Clk edge, in priority order:
  1. Reset: clear all outputs.
  2. Hold: all outputs keep their values. Stall output=0; upstream freezing is owned by the hazard unit's Hold path.
  3. Flush: insert a bubble (Valid_EX=0, WrEn_EX=0, Dst_EX=0, OpA_EX=0, OpB_EX=0). Flush wins over Stall.
  4. Stall: insert a bubble. The ID instruction stays upstream and is re-evaluated the next cycle, when the load is in MEM and forwards via Mem_Res.
  5. Otherwise, capture: OpA_EX/OpB_EX = selected operands, Dst_EX=Dst_ID, WrEn_EX=WrEn_ID&Valid_ID, Valid_EX=Valid_ID.
- Latency: 1 cycle from ID inputs to EX outputs. A load-use hazard adds exactly 1 bubble cycle.
- Operands are captured even when UseX=0; the value is don't-care but deterministic per the selection rules.

Test Plan:
- Reset: drive Reset=1 for 1 edge with all inputs nonzero -> all five registered outputs 0 on the next cycle. Release -> the normal capture occurs on the next edge.
- Plain pass-through: A=3, B=4, PA=32'h11, PB=32'h22, no writes pending, Valid_ID=1, Dst_ID=5, WrEn_ID=1 -> after 1 edge OpA_EX=32'h11, OpB_EX=32'h22, Dst_EX=5, WrEn_EX=1, Valid_EX=1. FwdA=FwdB=0.
- Forward priority: A=B=7, with Ex_Dst=Mem_Dst=Wb_Dst=7, all WrEn=1, Ex_Res=1, Mem_Res=2, Wb_Res=3 -> OpA_EX=OpB_EX=1, FwdA=1. Drop Ex_WrEn -> 2. Then drop Mem_WrEn -> 3.
- R15 read: A=15, PC_ID=32'h100, Ex_Dst=15 with Ex_WrEn=1 -> OpA_EX=32'h108, FwdA=0. PC_ID=32'hFFFFFFFC -> OpA_EX=32'h4 (wrap).
- Load-use: Ex_IsLoad=1, Ex_Dst=2, Ex_WrEn=1, A=2, UseA=1 -> Stall=1, Valid_EX=0 next cycle. Next cycle Mem_Dst=2, Mem_Res=32'hABCD, Ex_IsLoad=0 -> Stall=0, OpA_EX=32'hABCD. Repeat with UseA=0 -> no stall.
- Simultaneous events:
  - Stall condition plus Flush=1 -> Stall=0, bubble.
  - Hold=1 with the stall condition -> outputs unchanged, Stall=0.
  - Reset=1 with Hold=1 -> outputs cleared.

Source files
------------

// File: rtl/id_ex_operand_stage.sv
// ---------------------------------------------------------------------------
// id_ex_operand_stage
//
// ID/EX pipeline stage that sits after the 16x32 register file. It resolves
// both source operands for the instruction in ID:
//   - R15 reads return PC_ID + PC_OFFSET. This value wraps modulo 2^DW and
//     is never forwarded.
//   - Other reads are forwarded from the youngest producer that has a match.
//     The order is EX, then MEM, then WB. The register-file port is used
//     only when no stage matches.
// It also detects load-use hazards and raises Stall. Operands and control
// are registered into EX, with support for hold, flush bubbles and stall
// bubbles.
//
// Ports
//   Clk, Reset            rising-edge clock; synchronous active-high reset
//   PA, PB                register-file read data for selects A, B
//   A, B                  source register numbers
//   UseA, UseB            instruction actually reads A / B
//   PC_ID                 address of the ID instruction
//   Dst_ID, WrEn_ID       destination and write enable of the ID instruction
//   Valid_ID              ID holds a real instruction
//   Flush                 kill the ID instruction (branch taken)
//   Hold                  freeze this stage (downstream multi-cycle busy)
//   Ex_/Mem_/Wb_Res       results of the EX, MEM and WB stages
//   Ex_/Mem_/Wb_Dst       destination registers of those stages
//   Ex_/Mem_/Wb_WrEn      write enables of those stages
//   Ex_IsLoad             EX instruction is a load; its data arrives in MEM
//   OpA_EX, OpB_EX        registered operands
//   Dst_EX, WrEn_EX       registered destination / write enable
//   Valid_EX              registered valid
//   Stall                 combinational load-use stall request
//   FwdA, FwdB            combinational forwarding selects
//                         (0 = RF or PC, 1 = EX, 2 = MEM, 3 = WB)
// ---------------------------------------------------------------------------
module id_ex_operand_stage #(
    parameter int DW        = 32,
    parameter int RW        = 4,
    parameter int PC_OFFSET = 8
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic [DW-1:0] PA,
    input  logic [DW-1:0] PB,
    input  logic [RW-1:0] A,
    input  logic [RW-1:0] B,
    input  logic          UseA,
    input  logic          UseB,
    input  logic [DW-1:0] PC_ID,
    input  logic [RW-1:0] Dst_ID,
    input  logic          WrEn_ID,
    input  logic          Valid_ID,
    input  logic          Flush,
    input  logic          Hold,
    input  logic [DW-1:0] Ex_Res,
    input  logic [DW-1:0] Mem_Res,
    input  logic [DW-1:0] Wb_Res,
    input  logic [RW-1:0] Ex_Dst,
    input  logic [RW-1:0] Mem_Dst,
    input  logic [RW-1:0] Wb_Dst,
    input  logic          Ex_WrEn,
    input  logic          Mem_WrEn,
    input  logic          Wb_WrEn,
    input  logic          Ex_IsLoad,
    output logic [DW-1:0] OpA_EX,
    output logic [DW-1:0] OpB_EX,
    output logic [RW-1:0] Dst_EX,
    output logic          WrEn_EX,
    output logic          Valid_EX,
    output logic          Stall,
    output logic [1:0]    FwdA,
    output logic [1:0]    FwdB
);

    localparam logic [RW-1:0] PC_REG  = {RW{1'b1}};
    localparam logic [1:0]    SRC_RF  = 2'd0;
    localparam logic [1:0]    SRC_EX  = 2'd1;
    localparam logic [1:0]    SRC_MEM = 2'd2;
    localparam logic [1:0]    SRC_WB  = 2'd3;

    // Pick the youngest producer for one source register. A load in EX does
    // not have its data yet, so it never forwards from EX. That case is
    // covered by the load-use stall instead. R15 bypasses forwarding.
    function automatic logic [1:0] fwd_sel(
        input logic [RW-1:0] src,
        input logic          ex_we,
        input logic [RW-1:0] ex_dst,
        input logic          ex_ld,
        input logic          mem_we,
        input logic [RW-1:0] mem_dst,
        input logic          wb_we,
        input logic [RW-1:0] wb_dst
    );
        logic [1:0] sel;
        sel = SRC_RF;
        if (src != PC_REG) begin
            if (ex_we && (ex_dst == src) && (ex_dst != PC_REG) && !ex_ld)
                sel = SRC_EX;
            else if (mem_we && (mem_dst == src) && (mem_dst != PC_REG))
                sel = SRC_MEM;
            else if (wb_we && (wb_dst == src) && (wb_dst != PC_REG))
                sel = SRC_WB;
        end
        return sel;
    endfunction

    function automatic logic [DW-1:0] operand_mux(
        input logic [RW-1:0] src,
        input logic [1:0]    sel,
        input logic [DW-1:0] rf_val,
        input logic [DW-1:0] pc_val,
        input logic [DW-1:0] ex_val,
        input logic [DW-1:0] mem_val,
        input logic [DW-1:0] wb_val
    );
        logic [DW-1:0] val;
        if (src == PC_REG) begin
            val = pc_val;
        end else begin
            unique case (sel)
                SRC_EX:  val = ex_val;
                SRC_MEM: val = mem_val;
                SRC_WB:  val = wb_val;
                default: val = rf_val;
            endcase
        end
        return val;
    endfunction

    // ---- ID stage (p0): operand resolution and hazard detection ----
    logic [DW-1:0] pc_plus_p0;
    logic [1:0]    fwd_a_p0;
    logic [1:0]    fwd_b_p0;
    logic [DW-1:0] op_a_p0;
    logic [DW-1:0] op_b_p0;
    logic          ld_hit_p0;
    logic          stall_p0;

    assign pc_plus_p0 = PC_ID + DW'(PC_OFFSET);

    assign fwd_a_p0 = fwd_sel(A, Ex_WrEn, Ex_Dst, Ex_IsLoad,
                              Mem_WrEn, Mem_Dst, Wb_WrEn, Wb_Dst);
    assign fwd_b_p0 = fwd_sel(B, Ex_WrEn, Ex_Dst, Ex_IsLoad,
                              Mem_WrEn, Mem_Dst, Wb_WrEn, Wb_Dst);

    assign op_a_p0 = operand_mux(A, fwd_a_p0, PA, pc_plus_p0,
                                 Ex_Res, Mem_Res, Wb_Res);
    assign op_b_p0 = operand_mux(B, fwd_b_p0, PB, pc_plus_p0,
                                 Ex_Res, Mem_Res, Wb_Res);

    // Ex_Dst==R15 never stalls. That also covers an R15 source, because the
    // source would have to equal Ex_Dst. While Hold is asserted the hazard
    // unit freezes the upstream stages itself, so no stall is requested.
    assign ld_hit_p0 = (UseA && (A == Ex_Dst)) || (UseB && (B == Ex_Dst));
    assign stall_p0  = Valid_ID && Ex_IsLoad && Ex_WrEn && (Ex_Dst != PC_REG)
                       && ld_hit_p0 && !Flush && !Hold;

    assign Stall = stall_p0;
    assign FwdA  = fwd_a_p0;
    assign FwdB  = fwd_b_p0;

    // ---- EX stage (p1): ID/EX pipeline register ----
    logic [DW-1:0] op_a_p1;
    logic [DW-1:0] op_b_p1;
    logic [RW-1:0] dst_p1;
    logic          wr_p1;
    logic          vld_p1;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            op_a_p1 <= '0;
            op_b_p1 <= '0;
            dst_p1  <= '0;
            wr_p1   <= 1'b0;
            vld_p1  <= 1'b0;
        end else if (Hold) begin
            op_a_p1 <= op_a_p1;
            op_b_p1 <= op_b_p1;
            dst_p1  <= dst_p1;
            wr_p1   <= wr_p1;
            vld_p1  <= vld_p1;
        end else if (Flush || stall_p0) begin
            // Bubble: on a stall the ID instruction stays upstream and is
            // re-resolved next cycle, once the load result is in MEM.
            op_a_p1 <= '0;
            op_b_p1 <= '0;
            dst_p1  <= '0;
            wr_p1   <= 1'b0;
            vld_p1  <= 1'b0;
        end else begin
            op_a_p1 <= op_a_p0;
            op_b_p1 <= op_b_p0;
            dst_p1  <= Dst_ID;
            wr_p1   <= WrEn_ID && Valid_ID;
            vld_p1  <= Valid_ID;
        end
    end

    assign OpA_EX   = op_a_p1;
    assign OpB_EX   = op_b_p1;
    assign Dst_EX   = dst_p1;
    assign WrEn_EX  = wr_p1;
    assign Valid_EX = vld_p1;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
module tb_id_ex_operand_stage;

    localparam int DW = 32;
    localparam int RW = 4;

    logic          Clk = 1'b0;
    logic          Reset;
    logic [DW-1:0] PA, PB, PC_ID, Ex_Res, Mem_Res, Wb_Res;
    logic [RW-1:0] A, B, Dst_ID, Ex_Dst, Mem_Dst, Wb_Dst;
    logic          UseA, UseB, WrEn_ID, Valid_ID, Flush, Hold;
    logic          Ex_WrEn, Mem_WrEn, Wb_WrEn, Ex_IsLoad;
    logic [DW-1:0] OpA_EX, OpB_EX;
    logic [RW-1:0] Dst_EX;
    logic          WrEn_EX, Valid_EX, Stall;
    logic [1:0]    FwdA, FwdB;

    always #5 Clk = ~Clk;

    id_ex_operand_stage #(.DW(DW), .RW(RW), .PC_OFFSET(8)) dut (
        .Clk(Clk), .Reset(Reset), .PA(PA), .PB(PB), .A(A), .B(B),
        .UseA(UseA), .UseB(UseB), .PC_ID(PC_ID), .Dst_ID(Dst_ID),
        .WrEn_ID(WrEn_ID), .Valid_ID(Valid_ID), .Flush(Flush), .Hold(Hold),
        .Ex_Res(Ex_Res), .Mem_Res(Mem_Res), .Wb_Res(Wb_Res),
        .Ex_Dst(Ex_Dst), .Mem_Dst(Mem_Dst), .Wb_Dst(Wb_Dst),
        .Ex_WrEn(Ex_WrEn), .Mem_WrEn(Mem_WrEn), .Wb_WrEn(Wb_WrEn),
        .Ex_IsLoad(Ex_IsLoad), .OpA_EX(OpA_EX), .OpB_EX(OpB_EX),
        .Dst_EX(Dst_EX), .WrEn_EX(WrEn_EX), .Valid_EX(Valid_EX),
        .Stall(Stall), .FwdA(FwdA), .FwdB(FwdB)
    );

    typedef struct {
        string         name;
        logic          rst, flush, hold;
        logic [31:0]   pa, pb, pc, ex_res, mem_res, wb_res;
        logic [3:0]    a, b, dst_id, ex_dst, mem_dst, wb_dst;
        logic          use_a, use_b, wr_id, vld_id;
        logic          ex_we, mem_we, wb_we, ex_ld;
        // expected: combinational (before edge) then registered (after edge)
        logic          e_stall;
        logic [1:0]    e_fwda, e_fwdb;
        logic [31:0]   e_opa, e_opb;
        logic [3:0]    e_dst;
        logic          e_wr, e_vld;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   n_cmp = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t base(input string name);
        vec_t v;
        v = '{default: 0};
        v.name = name;
        return v;
    endfunction

    // Load in EX writing R2; ID reads R2 on A (UseA=1), R3 on B.
    function automatic vec_t load_use(input string name);
        vec_t v;
        v = base(name);
        v.a = 4'd2; v.b = 4'd3; v.use_a = 1; v.use_b = 1;
        v.pa = 32'h77; v.pb = 32'h33;
        v.vld_id = 1; v.dst_id = 4'd8; v.wr_id = 1;
        v.ex_ld = 1; v.ex_dst = 4'd2; v.ex_we = 1; v.ex_res = 32'h999;
        return v;
    endfunction

    function automatic vec_t pass_thru(input string name);
        vec_t v;
        v = base(name);
        v.a = 4'd3; v.b = 4'd4; v.use_a = 1; v.use_b = 1;
        v.pa = 32'h11; v.pb = 32'h22;
        v.vld_id = 1; v.dst_id = 4'd5; v.wr_id = 1;
        v.e_opa = 32'h11; v.e_opb = 32'h22; v.e_dst = 4'd5; v.e_wr = 1; v.e_vld = 1;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        Reset = v.rst; Flush = v.flush; Hold = v.hold;
        PA = v.pa; PB = v.pb; A = v.a; B = v.b; UseA = v.use_a; UseB = v.use_b;
        PC_ID = v.pc; Dst_ID = v.dst_id; WrEn_ID = v.wr_id; Valid_ID = v.vld_id;
        Ex_Res = v.ex_res; Mem_Res = v.mem_res; Wb_Res = v.wb_res;
        Ex_Dst = v.ex_dst; Mem_Dst = v.mem_dst; Wb_Dst = v.wb_dst;
        Ex_WrEn = v.ex_we; Mem_WrEn = v.mem_we; Wb_WrEn = v.wb_we;
        Ex_IsLoad = v.ex_ld;
    endtask

    task automatic check_regs(input string tag, input logic [31:0] opa, input logic [31:0] opb,
                              input logic [3:0] dst, input logic wr, input logic vld);
        chk({tag, ".OpA_EX"}, OpA_EX, opa);
        chk({tag, ".OpB_EX"}, OpB_EX, opb);
        chk({tag, ".Dst_EX"}, {28'd0, Dst_EX}, {28'd0, dst});
        chk({tag, ".WrEn_EX"}, {31'd0, WrEn_EX}, {31'd0, wr});
        chk({tag, ".Valid_EX"}, {31'd0, Valid_EX}, {31'd0, vld});
    endtask

    initial begin
        vec_t v;
        vec_t h;

        // Reset with every input nonzero (Hold and Flush too): cleared.
        v = base("reset_all_nonzero");
        v.rst = 1; v.flush = 1; v.hold = 1;
        v.pa = 32'h55; v.pb = 32'h66; v.a = 4'd1; v.b = 4'd2; v.use_a = 1; v.use_b = 1;
        v.pc = 32'h200; v.dst_id = 4'd9; v.wr_id = 1; v.vld_id = 1;
        v.ex_res = 32'hE; v.mem_res = 32'hF; v.wb_res = 32'h10;
        v.ex_dst = 4'd1; v.mem_dst = 4'd2; v.wb_dst = 4'd3;
        v.ex_we = 1; v.mem_we = 1; v.wb_we = 1; v.ex_ld = 1;
        v.e_fwda = 2'd0; v.e_fwdb = 2'd2;   // load blocks EX fwd of A; B hits MEM
        vecs.push_back(v);

        vecs.push_back(pass_thru("pass_through"));

        // Forwarding priority, all three stages writing R7.
        v = base("fwd_ex");
        v.a = 4'd7; v.b = 4'd7; v.use_a = 1; v.use_b = 1; v.pa = 32'hAA; v.pb = 32'hBB;
        v.vld_id = 1; v.dst_id = 4'd6; v.wr_id = 1;
        v.ex_dst = 4'd7; v.mem_dst = 4'd7; v.wb_dst = 4'd7;
        v.ex_we = 1; v.mem_we = 1; v.wb_we = 1;
        v.ex_res = 32'h1; v.mem_res = 32'h2; v.wb_res = 32'h3;
        v.e_fwda = 2'd1; v.e_fwdb = 2'd1; v.e_opa = 32'h1; v.e_opb = 32'h1;
        v.e_dst = 4'd6; v.e_wr = 1; v.e_vld = 1;
        vecs.push_back(v);
        v.name = "fwd_mem"; v.ex_we = 0;
        v.e_fwda = 2'd2; v.e_fwdb = 2'd2; v.e_opa = 32'h2; v.e_opb = 32'h2;
        vecs.push_back(v);
        v.name = "fwd_wb"; v.mem_we = 0;
        v.e_fwda = 2'd3; v.e_fwdb = 2'd3; v.e_opa = 32'h3; v.e_opb = 32'h3;
        vecs.push_back(v);
        v.name = "fwd_none"; v.wb_we = 0;
        v.e_fwda = 2'd0; v.e_fwdb = 2'd0; v.e_opa = 32'hAA; v.e_opb = 32'hBB;
        vecs.push_back(v);
        // A hits MEM, B hits WB simultaneously: selection is per source.
        v.name = "fwd_split"; v.a = 4'd6; v.b = 4'd9;
        v.mem_dst = 4'd6; v.mem_we = 1; v.wb_dst = 4'd9; v.wb_we = 1;
        v.e_fwda = 2'd2; v.e_fwdb = 2'd3; v.e_opa = 32'h2; v.e_opb = 32'h3;
        vecs.push_back(v);

        // R15 reads: PC+8, ignoring an EX write to R15.
        v = base("r15_pc");
        v.a = 4'd15; v.b = 4'd4; v.use_a = 1; v.use_b = 1; v.pa = 32'h5A; v.pb = 32'h22;
        v.pc = 32'h100; v.ex_dst = 4'd15; v.ex_we = 1; v.ex_res = 32'hDEAD;
        v.vld_id = 1; v.dst_id = 4'd1; v.wr_id = 0;
        v.e_opa = 32'h108; v.e_opb = 32'h22; v.e_dst = 4'd1; v.e_wr = 0; v.e_vld = 1;
        vecs.push_back(v);
        v.name = "r15_wrap"; v.pc = 32'hFFFF_FFFC; v.b = 4'd15;
        v.mem_dst = 4'd15; v.mem_we = 1; v.mem_res = 32'hBAD;
        v.e_opa = 32'h4; v.e_opb = 32'h4;
        vecs.push_back(v);

        // Load-use: one bubble, then MEM forwarding.
        v = load_use("load_use_stall");
        v.e_stall = 1;
        vecs.push_back(v);
        v = load_use("load_use_resolve");
        v.ex_ld = 0; v.ex_we = 0; v.mem_dst = 4'd2; v.mem_we = 1; v.mem_res = 32'hABCD;
        v.e_fwda = 2'd2; v.e_opa = 32'hABCD; v.e_opb = 32'h33;
        v.e_dst = 4'd8; v.e_wr = 1; v.e_vld = 1;
        vecs.push_back(v);
        v = load_use("load_unused_srcs");
        v.use_a = 0; v.use_b = 0;
        v.e_opa = 32'h77; v.e_opb = 32'h33; v.e_dst = 4'd8; v.e_wr = 1; v.e_vld = 1;
        vecs.push_back(v);
        v = load_use("load_use_flush");
        v.flush = 1;
        vecs.push_back(v);
        v = load_use("load_use_on_b");
        v.a = 4'd3; v.b = 4'd2; v.pa = 32'h44;
        v.e_stall = 1;
        vecs.push_back(v);
        v = load_use("load_invalid_id");
        v.vld_id = 0;
        v.e_opa = 32'h77; v.e_opb = 32'h33; v.e_dst = 4'd8; v.e_wr = 0; v.e_vld = 0;
        vecs.push_back(v);

        // Hold freezes the stage, including during a stall condition.
        vecs.push_back(pass_thru("pre_hold_capture"));
        v = load_use("hold_with_stall");
        v.hold = 1;
        v.e_opa = 32'h11; v.e_opb = 32'h22; v.e_dst = 4'd5; v.e_wr = 1; v.e_vld = 1;
        vecs.push_back(v);
        v = load_use("reset_with_hold");
        v.hold = 1; v.rst = 1;
        vecs.push_back(v);
        vecs.push_back(pass_thru("pre_flush_capture"));
        v = pass_thru("flush_only");
        v.flush = 1; v.e_opa = 0; v.e_opb = 0; v.e_dst = 0; v.e_wr = 0; v.e_vld = 0;
        vecs.push_back(v);

        @(negedge Clk);
        foreach (vecs[i]) begin
            drive(vecs[i]);
            #2;
            chk({vecs[i].name, ".Stall"}, {31'd0, Stall}, {31'd0, vecs[i].e_stall});
            chk({vecs[i].name, ".FwdA"}, {30'd0, FwdA}, {30'd0, vecs[i].e_fwda});
            chk({vecs[i].name, ".FwdB"}, {30'd0, FwdB}, {30'd0, vecs[i].e_fwdb});
            @(posedge Clk);
            #1;
            check_regs(vecs[i].name, vecs[i].e_opa, vecs[i].e_opb, vecs[i].e_dst,
                       vecs[i].e_wr, vecs[i].e_vld);
            n_vec++;
            @(negedge Clk);
        end

        // Hand sequence: capture, hold two cycles while inputs change, release.
        h = pass_thru("seq_capture");
        drive(h);
        @(posedge Clk); #1;
        check_regs("seq_capture", 32'h11, 32'h22, 4'd5, 1'b1, 1'b1);
        n_vec++;
        @(negedge Clk);
        h.pa = 32'hC0DE; h.pb = 32'hF00D; h.dst_id = 4'd12; h.wr_id = 0; h.hold = 1;
        drive(h);
        for (int k = 0; k < 2; k++) begin
            @(posedge Clk); #1;
            check_regs("seq_hold", 32'h11, 32'h22, 4'd5, 1'b1, 1'b1);
            n_vec++;
            @(negedge Clk);
        end
        h.hold = 0;
        drive(h);
        @(posedge Clk); #1;
        check_regs("seq_release", 32'hC0DE, 32'hF00D, 4'd12, 1'b0, 1'b1);
        n_vec++;

        // Hand sequence: back-to-back load-use stalls re-evaluate each cycle.
        @(negedge Clk);
        drive(load_use("seq_stall_1"));
        #2;
        chk("seq_stall_1.Stall", {31'd0, Stall}, 32'd1);
        @(posedge Clk); #1;
        chk("seq_stall_1.Valid_EX", {31'd0, Valid_EX}, 32'd0);
        @(negedge Clk);
        Ex_IsLoad = 1'b0;   // load moved on; EX now holds a plain ALU op to R2
        Ex_Res = 32'h1234;
        #2;
        chk("seq_stall_2.Stall", {31'd0, Stall}, 32'd0);
        chk("seq_stall_2.FwdA", {30'd0, FwdA}, 32'd1);
        @(posedge Clk); #1;
        check_regs("seq_stall_2", 32'h1234, 32'h33, 4'd8, 1'b1, 1'b1);
        n_vec += 2;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
